display_scan_controller: RTL

Sequencer and write arbiter for the 4-digit multiplexed seven-segment display. It replaces the free-running scan counter with a controlled scan: a programmable per-digit dwell time, an all-off blanking gap between digits to suppress ghosting, and a per-digit blank mask. It also owns the four digit value registers and arbitrates writes to them between two requesters with round-robin fairness. Its `digit_o` output feeds the bin-to-hex segment decoder, and its `T_o` output drives the anodes directly.

---
 rtl/display_scan_controller.sv | 110 +++++++++++
 1 files changed

// File: rtl/display_scan_controller.sv
// display_scan_controller: dwell/blank digit scan sequencer with round-robin digit write arbiter
// Ports: clk_50MHz_i/rst_sync_ha_i clock and sync reset; enable_i scan enable; blank_mask_i per-digit dark mask;
//        req/addr/data/gnt _a/_b two write requesters; digit_o selected digit value; sel_o digit index;
//        T_o active-low anodes; frame_o pulse on 3->0 wrap
module display_scan_controller #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic       clk_50MHz_i,
    input  logic       rst_sync_ha_i,
    input  logic       enable_i,
    input  logic [3:0] blank_mask_i,
    input  logic       req_a_i,
    input  logic [1:0] addr_a_i,
    input  logic [3:0] data_a_i,
    output logic       gnt_a_o,
    input  logic       req_b_i,
    input  logic [1:0] addr_b_i,
    input  logic [3:0] data_b_i,
    output logic       gnt_b_o,
    output logic [3:0] digit_o,
    output logic [1:0] sel_o,
    output logic [3:0] T_o,
    output logic       frame_o
);
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_e;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       sel_q;
    logic [3:0]       t_q;
    logic             frame_q, gnt_a_q, gnt_b_q, pri_b_q;
    logic [3:0]       dig_q [4];
    logic             win_a, win_b, dwell_done, blank_done;
    logic [1:0]       sel_d;

    // pri_b_q set means B wins a tie; it flips to the loser after every grant
    assign win_a      = req_a_i && (!req_b_i || !pri_b_q);
    assign win_b      = req_b_i && !win_a;
    assign dwell_done = cnt_q == CNT_W'(DWELL_CYCLES - 1);
    assign blank_done = cnt_q == CNT_W'(BLANK_CYCLES - 1);
    assign sel_d      = sel_q + 2'd1;

    always_ff @(posedge clk_50MHz_i) begin
        if (rst_sync_ha_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            t_q     <= 4'hF;
            frame_q <= 1'b0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            pri_b_q <= 1'b0;
            for (int i = 0; i < 4; i++) dig_q[i] <= '0;
        end else begin
            frame_q <= 1'b0;
            gnt_a_q <= win_a;
            gnt_b_q <= win_b;
            if (win_a) dig_q[addr_a_i] <= data_a_i;
            else if (win_b) dig_q[addr_b_i] <= data_b_i;
            if (win_a || win_b) pri_b_q <= win_a;
            if (!enable_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                t_q     <= 4'hF;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= SHOW;
                        cnt_q   <= '0;
                        t_q     <= ~(4'b0001 << sel_q);
                    end
                    SHOW: begin
                        if (dwell_done) begin
                            state_q <= BLANK;
                            cnt_q   <= '0;
                            t_q     <= 4'hF;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    BLANK: begin
                        if (blank_done) begin
                            state_q <= SHOW;
                            cnt_q   <= '0;
                            sel_q   <= sel_d;
                            t_q     <= ~(4'b0001 << sel_d);
                            frame_q <= sel_q == 2'd3;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        t_q     <= 4'hF;
                    end
                endcase
            end
        end
    end

    // the mask overrides the registered anode pattern immediately
    assign T_o     = t_q | {4{blank_mask_i[sel_q]}};
    assign sel_o   = sel_q;
    assign frame_o = frame_q;
    assign gnt_a_o = gnt_a_q;
    assign gnt_b_o = gnt_b_q;
    assign digit_o = dig_q[sel_q];
endmodule
